msx_mouse_host: RTL and testbench

Host-side reader for the MSX general-purpose-port mouse protocol. It drives the port strobe (pin 8) and samples the returned 4-bit nibbles, then assembles signed X/Y displacement bytes and the button states. It sits on a joystick port of the emsx top level, facing an external MSX mouse or an on-chip mouse emulator. Use it to feed PS/2-style motion into the MiST/OSD path, and to verify the mouse emulator end-to-end.

---
 rtl/msx_mouse_pkg.sv | 23 ++
 rtl/msx_mouse_host_sync2.sv | 18 +
 rtl/msx_mouse_host.sv | 112 +++++++++++
 tb/tb_msx_mouse_host.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_mouse_pkg.sv
// Shared types and helpers for the MSX general-purpose-port mouse host.
package msx_mouse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TOGGLE,
        SETTLE,
        SAMPLE,
        DONE,
        GAP
    } mouse_state_t;

    // One read is X high, X low, Y high, Y low.
    localparam int NIBBLES = 4;

    // The mouse reports negated motion; -(-128) does not fit, so clamp it to +127.
    function automatic logic [7:0] neg_sat8(input logic [7:0] raw);
        logic [7:0] negated;
        negated = ~raw + 8'd1;
        return (raw == 8'h80) ? 8'h7F : negated;
    endfunction

endpackage

// File: rtl/msx_mouse_host_sync2.sv
// Two-flop synchronizer for asynchronous port pins.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_sys,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages bring the pins into the clk_sys domain.
    always_ff @(posedge clk_sys) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/msx_mouse_host.sv
// Host-side MSX mouse reader: toggles the strobe four times, samples a
// nibble after each toggle, and publishes negated X/Y motion plus buttons.
module msx_mouse_host
    import msx_mouse_pkg::*;
#(
    parameter int SETTLE_CYC = 64,
    parameter int GAP_CYC    = 131072
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       req,
    input  logic [5:0] joy_in,
    output logic       stra,
    output logic       busy,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic [1:0] buttons,
    output logic       valid
);

    localparam int CNT_MAX = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // SETTLE starts one edge after the toggle, so the sample edge lands
    // exactly SETTLE_CYC edges after the toggle edge.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 2);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [1:0]       NIB_LAST    = 2'(NIBBLES - 1);

    mouse_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       nib_idx;
    logic [15:0]      shift_reg;
    logic [1:0]       btn_lat;
    logic [5:0]       joy_sync;

    sync2 #(.WIDTH(6)) u_sync (
        .clk_sys (clk_sys),
        .d       (joy_in),
        .q       (joy_sync)
    );

    // Read sequencer: strobe toggling, settle/gap counting, nibble capture
    // and output publication.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Forcing stra low may strand the mouse mid-sequence, so wait out
            // its resync timeout before accepting a request.
            state   <= GAP;
            cnt     <= '0;
            nib_idx <= '0;
            stra    <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            dx      <= '0;
            dy      <= '0;
            buttons <= '0;
        end else begin
            valid <= 1'b0;
            // busy trails the state by one edge; IDLE also checks it so the
            // first accepted request comes the edge after busy drops.
            busy  <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (req && !busy) begin
                        nib_idx <= '0;
                        state   <= TOGGLE;
                    end
                end
                TOGGLE: begin
                    stra  <= ~stra;
                    cnt   <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    shift_reg <= {shift_reg[11:0], joy_sync[3:0]};
                    if (nib_idx == NIB_LAST) begin
                        btn_lat <= ~joy_sync[5:4];
                        state   <= DONE;
                    end else begin
                        nib_idx <= nib_idx + 2'd1;
                        state   <= TOGGLE;
                    end
                end
                DONE: begin
                    dx      <= neg_sat8(shift_reg[15:8]);
                    dy      <= neg_sat8(shift_reg[7:0]);
                    buttons <= btn_lat;
                    valid   <= 1'b1;
                    cnt     <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msx_mouse_host.sv
// Bench for msx_mouse_host with a toggle-driven MSX mouse responder model.
module tb_msx_mouse_host;

    localparam int S   = 64;
    localparam int GAP = 400;
    localparam int TMO = 300;
    localparam int LAST = 4 * S + 6 + GAP;

    logic       clk_sys;
    logic       reset;
    logic       req;
    logic [5:0] joy_in;
    logic       stra;
    logic       busy;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] buttons;
    logic       valid;

    int n_checks = 0;
    int n_errors = 0;

    // Responder model state
    logic [7:0] x_next = 8'h00;
    logic [7:0] y_next = 8'h00;
    logic [1:0] btn    = 2'b00;
    logic [7:0] lat_x  = 8'h00;
    logic [7:0] lat_y  = 8'h00;
    logic       m_prev = 1'b0;
    int         m_idx  = 0;
    int         m_silent = 0;
    int         nib_log[$];

    msx_mouse_host #(.SETTLE_CYC(S), .GAP_CYC(GAP)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .req     (req),
        .joy_in  (joy_in),
        .stra    (stra),
        .busy    (busy),
        .dx      (dx),
        .dy      (dy),
        .buttons (buttons),
        .valid   (valid)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Mouse model: each strobe edge presents the next nibble; motion is
    // latched on the first edge; silence beyond TMO cycles restarts the sequence.
    always @(negedge clk_sys) begin
        if (stra === 1'b0 || stra === 1'b1) begin
            if (stra !== m_prev) begin
                m_prev   = stra;
                m_silent = 0;
                if (m_idx == 0) begin
                    lat_x = x_next;
                    lat_y = y_next;
                end
                case (m_idx)
                    0:       joy_in[3:0] = lat_x[7:4];
                    1:       joy_in[3:0] = lat_x[3:0];
                    2:       joy_in[3:0] = lat_y[7:4];
                    default: joy_in[3:0] = lat_y[3:0];
                endcase
                nib_log.push_back(m_idx + 1);
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_silent++;
                if (m_silent >= TMO) m_idx = 0;
            end
        end
        joy_in[5:4] = ~btn;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: negate the raw two's-complement byte, clamping +128 to +127.
    function automatic logic [7:0] ref_neg(input logic [7:0] raw);
        int v;
        v = (raw >= 8'd128) ? int'(raw) - 256 : int'(raw);
        v = -v;
        if (v > 127) v = 127;
        return 8'(v & 255);
    endfunction

    // Full read with edge-accurate checks; optional rejected req pulses and
    // an early back-to-back request probing the earliest accepted edge.
    task automatic run_read(input logic [7:0] x, input logic [7:0] y, input logic [1:0] b,
                            input bit rej, input bit early);
        int n_tog, n_val, rise, fall, last_e;
        logic sprev, bprev;
        x_next = x;
        y_next = y;
        btn    = b;
        @(negedge clk_sys);
        req = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        req   = 1'b0;
        n_tog = 0;
        n_val = 0;
        rise  = -1;
        fall  = -1;
        sprev = stra;
        bprev = busy;
        last_e = early ? LAST + 2 : LAST;
        for (int e = 1; e <= last_e; e++) begin
            @(negedge clk_sys);
            if (stra !== sprev) begin
                sprev = stra;
                if (e <= LAST) begin
                    if (n_tog < 4) check("toggle_edge", e, 1 + n_tog * (S + 1));
                    n_tog++;
                end
            end
            if (valid === 1'b1) begin
                n_val++;
                if (n_val == 1) begin
                    check("valid_edge", e, 4 * S + 5);
                    check("dx", dx, ref_neg(x));
                    check("dy", dy, ref_neg(y));
                    check("buttons", buttons, b);
                end
            end
            if (busy === 1'b1 && bprev === 1'b0 && rise < 0) rise = e;
            if (busy === 1'b0 && bprev === 1'b1 && fall < 0) fall = e;
            bprev = busy;
            if (e == LAST) check("stra_final", stra, 1'b0);
            if (early && e == LAST + 1) check("early_rejected", stra, 1'b0);
            if (early && e == LAST + 2) check("early_accepted", stra, 1'b1);
            req = (rej && (e + 1 == 50 || e + 1 == 4 * S + 6 + GAP / 2)) ||
                  (early && e + 1 >= LAST);
        end
        req = 1'b0;
        check("toggle_count", n_tog, 4);
        check("valid_count", n_val, 1);
        check("busy_rise", rise, 1);
        check("busy_fall", fall, LAST);
    endtask

    // Wait for a read already in flight, check its result, then its gap.
    task automatic finish_read(input logic [7:0] x, input logic [7:0] y, input logic [1:0] b);
        bit got;
        got = 0;
        for (int i = 0; i < 8 * S && !got; i++) begin
            @(negedge clk_sys);
            if (valid === 1'b1) got = 1;
        end
        check("fin_valid_seen", got, 1'b1);
        check("fin_dx", dx, ref_neg(x));
        check("fin_dy", dy, ref_neg(y));
        check("fin_buttons", buttons, b);
        got = 0;
        for (int i = 0; i < GAP + 50 && !got; i++) begin
            @(negedge clk_sys);
            if (busy === 1'b0) got = 1;
        end
        check("fin_busy_low", got, 1'b1);
        check("fin_stra", stra, 1'b0);
    endtask

    initial begin
        int   tog_off, nv;
        bit   seen;
        logic sp;
        logic [7:0] rx, ry;
        logic [1:0] rb;

        reset = 1'b1;
        req   = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_stra", stra, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_dx", dx, 8'h00);
        check("rst_dy", dy, 8'h00);
        check("rst_buttons", buttons, 2'b00);

        // Release reset with req held: the first toggle must wait out GAP.
        x_next = 8'h05;
        y_next = 8'hFB;
        btn    = 2'b01;
        reset  = 1'b0;
        req    = 1'b1;
        tog_off = -1;
        sp = stra;
        for (int e = 1; e <= GAP + 20 && tog_off < 0; e++) begin
            @(negedge clk_sys);
            if (stra !== sp) tog_off = e;
        end
        req = 1'b0;
        check("post_reset_wait_min", (tog_off > GAP), 1'b1);
        check("post_reset_wait_max", (tog_off <= GAP + 3), 1'b1);
        finish_read(8'h05, 8'hFB, 2'b01);

        // Basic read
        run_read(8'h05, 8'hFB, 2'b01, 1'b0, 1'b0);

        // Nibble order
        nib_log.delete();
        run_read(8'h12, 8'h34, 2'b00, 1'b0, 1'b0);
        check("nib_count", nib_log.size(), 4);
        for (int i = 0; i < 4 && i < nib_log.size(); i++) check("nib_order", nib_log[i], i + 1);
        check("shift_reg", dut.shift_reg, 16'h1234);
        check("order_dx", dx, 8'hEE);
        check("order_dy", dy, 8'hCC);

        // Saturation
        run_read(8'h80, 8'h7F, 2'b10, 1'b0, 1'b0);
        check("sat_dx", dx, 8'h7F);
        check("sat_dy", dy, 8'h81);

        // Busy rejection plus earliest acceptance of the next request
        run_read(8'hC3, 8'h01, 2'b11, 1'b1, 1'b1);
        finish_read(8'hC3, 8'h01, 2'b11);

        // Outputs hold between reads
        repeat (10) @(negedge clk_sys);
        check("hold_dx", dx, ref_neg(8'hC3));
        check("hold_dy", dy, ref_neg(8'h01));

        // Reset mid-read after toggle 2
        x_next = 8'h77;
        y_next = 8'h66;
        btn    = 2'b11;
        @(negedge clk_sys);
        req = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        req = 1'b0;
        for (int e = 1; e < 2 * (S + 1) + 4; e++) @(negedge clk_sys);
        check("mid_stra_before", stra, 1'b1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("mid_stra_after", stra, 1'b0);
        check("mid_busy_after", busy, 1'b0);
        check("mid_valid_after", valid, 1'b0);
        reset = 1'b0;
        nv = 0;
        seen = 0;
        sp = stra;
        for (int i = 0; i < ((GAP > TMO) ? GAP : TMO) + 30; i++) begin
            @(negedge clk_sys);
            if (valid === 1'b1) nv++;
            if (stra !== sp) seen = 1;
        end
        check("mid_no_valid", nv, 0);
        check("mid_no_toggle", seen, 1'b0);
        check("mid_busy_idle", busy, 1'b0);
        run_read(8'h05, 8'hFB, 2'b01, 1'b0, 1'b0);

        // Randomized reads
        for (int i = 0; i < 6; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rb = 2'($urandom_range(0, 3));
            run_read(rx, ry, rb, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
